// File: rtl/proc_ctrl_pkg.sv
// Shared constants and types for the processor control unit.
package proc_ctrl_pkg;

    // ALU opcode used to compute PC+1
    localparam logic [5:0] OP_ADD = 6'b000000;

    // Non-ALU opcodes
    localparam logic [5:0] OpLoad  = 6'b100000;
    localparam logic [5:0] OpStore = 6'b100001;
    localparam logic [5:0] OpJmp   = 6'b110000;
    localparam logic [5:0] OpJz    = 6'b110001;
    localparam logic [5:0] OpHalt  = 6'b111111;

    // Status bit tested by JZ and width of the absolute jump target
    localparam int unsigned FLAG_Z_IDX = 1;
    localparam int unsigned JMP_W      = 10;

    // Instruction field positions
    localparam int unsigned OpMsb = 15;
    localparam int unsigned OpLsb = 10;
    localparam int unsigned RdMsb = 9;
    localparam int unsigned RdLsb = 5;
    localparam int unsigned RsMsb = 4;
    localparam int unsigned RsLsb = 0;

    // Register file write-data source select
    localparam logic [1:0] DinMem  = 2'b00;
    localparam logic [1:0] DinAlu  = 2'b01;
    localparam logic [1:0] DinTemp = 2'b10;

    typedef enum logic [3:0] {
        StReset,
        StFetch,
        StDecode,
        StExec,
        StMem,
        StWb,
        StPcinc,
        StJump,
        StHalt
    } state_e;

    typedef enum logic [2:0] {
        ClsAluReg,
        ClsAluImm,
        ClsLoad,
        ClsStore,
        ClsJmp,
        ClsJz,
        ClsHalt,
        ClsIllegal
    } instr_cls_e;

endpackage

// File: rtl/instr_decoder.sv
// Combinational opcode classifier: opcode -> instruction class and ALU operation.
module instr_decoder
    import proc_ctrl_pkg::*;
(
    input  logic [5:0] op_i,
    output instr_cls_e cls_o,
    output logic [5:0] alu_op_o
);

    // Both ALU forms share the low four opcode bits as the ALU operation
    always_comb begin
        alu_op_o = {2'b00, op_i[3:0]};
        cls_o    = ClsIllegal;
        if (op_i[5:4] == 2'b00) begin
            cls_o = ClsAluReg;
        end else if (op_i[5:4] == 2'b01) begin
            cls_o = ClsAluImm;
        end else begin
            case (op_i)
                OpLoad:  cls_o = ClsLoad;
                OpStore: cls_o = ClsStore;
                OpJmp:   cls_o = ClsJmp;
                OpJz:    cls_o = ClsJz;
                OpHalt:  cls_o = ClsHalt;
                default: cls_o = ClsIllegal;
            endcase
        end
    end

endmodule

// File: rtl/proc_control_unit.sv
// Multi-cycle control sequencer for the 16-bit processor datapath.
module proc_control_unit
    import proc_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        Rst,
    input  logic        run,
    input  logic [15:0] inst,
    input  logic [4:0]  flags_out,
    output logic [5:0]  opcode,
    output logic [4:0]  reg_addr1,
    output logic [4:0]  reg_addr2,
    output logic [4:0]  imd_operand,
    output logic [4:0]  mem_addr,
    output logic [15:0] imd_addr,
    output logic [1:0]  Din_Sel,
    output logic        mem_wr,
    output logic        reg_wr,
    output logic        IorR,
    output logic        PcorR,
    output logic        Pc_Rst,
    output logic        Pc_Ld,
    output logic        st_reg_ld,
    output logic        pc_addr_sel,
    output logic        halted,
    output logic        illegal
);

    state_e      state_q, state_d;
    logic [15:0] ir_q, ir_d;
    logic [5:0]  dec_op;
    logic [5:0]  alu_op;
    instr_cls_e  cls;
    logic [4:0]  rd, rs;
    logic        unused_flags;

    // In DECODE the IR is not yet loaded, so classify the live instruction word
    assign dec_op = (state_q == StDecode) ? inst[OpMsb:OpLsb] : ir_q[OpMsb:OpLsb];
    assign rd     = ir_q[RdMsb:RdLsb];
    assign rs     = ir_q[RsMsb:RsLsb];
    assign ir_d   = (state_q == StDecode) ? inst : ir_q;

    assign unused_flags = ^flags_out;

    instr_decoder u_instr_decoder (
        .op_i     (dec_op),
        .cls_o    (cls),
        .alu_op_o (alu_op)
    );

    // State and instruction register; reset aborts any instruction in flight
    always_ff @(posedge clk or negedge Rst) begin
        if (!Rst) begin
            state_q <= StReset;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
        end
    end

    // Next-state selection and per-state datapath controls
    always_comb begin
        state_d     = state_q;
        opcode      = '0;
        reg_addr1   = '0;
        reg_addr2   = '0;
        imd_operand = '0;
        mem_addr    = '0;
        imd_addr    = '0;
        Din_Sel     = DinMem;
        mem_wr      = 1'b0;
        reg_wr      = 1'b0;
        IorR        = 1'b0;
        PcorR       = 1'b0;
        Pc_Rst      = 1'b0;
        Pc_Ld       = 1'b0;
        st_reg_ld   = 1'b0;
        pc_addr_sel = 1'b0;
        halted      = 1'b0;
        illegal     = 1'b0;

        unique case (state_q)
            StReset: begin
                Pc_Rst = 1'b1;
                if (run) state_d = StFetch;
            end
            StFetch: state_d = StDecode;
            StDecode: begin
                case (cls)
                    ClsAluReg, ClsAluImm: state_d = StExec;
                    ClsLoad, ClsStore:    state_d = StMem;
                    ClsJmp:               state_d = StJump;
                    ClsJz:   state_d = flags_out[FLAG_Z_IDX] ? StJump : StPcinc;
                    ClsHalt: state_d = StHalt;
                    default: begin
                        illegal = 1'b1;
                        state_d = StPcinc;
                    end
                endcase
            end
            StExec: begin
                opcode      = alu_op;
                reg_addr1   = rd;
                reg_addr2   = rs;
                imd_operand = rs;
                IorR        = (cls == ClsAluImm);
                st_reg_ld   = 1'b1;
                state_d     = StWb;
            end
            StMem: begin
                mem_addr  = rs;
                reg_addr1 = rd;
                mem_wr    = (cls == ClsStore);
                state_d   = (cls == ClsLoad) ? StWb : StPcinc;
            end
            StWb: begin
                reg_wr  = 1'b1;
                state_d = StPcinc;
                if (cls == ClsLoad) begin
                    // Memory data arrives one cycle after the MEM-state address
                    mem_addr  = rs;
                    reg_addr1 = rd;
                    Din_Sel   = DinMem;
                end else begin
                    // Keep ALU operands live so the result is still valid at write-back
                    opcode      = alu_op;
                    reg_addr1   = rd;
                    reg_addr2   = rs;
                    imd_operand = rs;
                    IorR        = (cls == ClsAluImm);
                    Din_Sel     = DinAlu;
                end
            end
            StPcinc: begin
                // PC + 1 through the ALU using the immediate path
                PcorR       = 1'b1;
                IorR        = 1'b1;
                imd_operand = 5'd1;
                opcode      = OP_ADD;
                Pc_Ld       = 1'b1;
                state_d     = StFetch;
            end
            StJump: begin
                imd_addr    = {{(16 - JMP_W){1'b0}}, ir_q[JMP_W-1:0]};
                pc_addr_sel = 1'b1;
                Pc_Ld       = 1'b1;
                state_d     = StFetch;
            end
            StHalt: halted = 1'b1;
            default: state_d = StReset;
        endcase
    end

endmodule

// File: tb/tb_proc_control_unit.sv
// Self-checking bench for proc_control_unit: directed vector table, corner sequences, random program.
module tb_proc_control_unit;

    typedef struct packed {
        logic [5:0]  opcode;
        logic [4:0]  ra1;
        logic [4:0]  ra2;
        logic [4:0]  imd;
        logic [4:0]  maddr;
        logic [15:0] iaddr;
        logic [1:0]  din;
        logic        mem_wr;
        logic        reg_wr;
        logic        iorr;
        logic        pcorr;
        logic        pc_rst;
        logic        pc_ld;
        logic        st_ld;
        logic        pas;
        logic        halted;
        logic        illegal;
    } obs_t;

    typedef struct {
        logic [15:0] ins;
        logic [4:0]  fl;
        int          lat;
        int          nrw;
        int          nmw;
        int          nill;
        int          njmp;
    } vec_t;

    logic        clk = 1'b0;
    logic        Rst;
    logic        run;
    logic [15:0] inst;
    logic [4:0]  flags_out;
    logic [5:0]  opcode;
    logic [4:0]  reg_addr1, reg_addr2, imd_operand, mem_addr;
    logic [15:0] imd_addr;
    logic [1:0]  Din_Sel;
    logic        mem_wr, reg_wr, IorR, PcorR, Pc_Rst, Pc_Ld, st_reg_ld, pc_addr_sel;
    logic        halted, illegal;

    obs_t act;
    obs_t exp_q[$];
    obs_t reset_e;
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    assign act = {opcode, reg_addr1, reg_addr2, imd_operand, mem_addr, imd_addr, Din_Sel,
                  mem_wr, reg_wr, IorR, PcorR, Pc_Rst, Pc_Ld, st_reg_ld, pc_addr_sel,
                  halted, illegal};

    proc_control_unit dut (
        .clk         (clk),
        .Rst         (Rst),
        .run         (run),
        .inst        (inst),
        .flags_out   (flags_out),
        .opcode      (opcode),
        .reg_addr1   (reg_addr1),
        .reg_addr2   (reg_addr2),
        .imd_operand (imd_operand),
        .mem_addr    (mem_addr),
        .imd_addr    (imd_addr),
        .Din_Sel     (Din_Sel),
        .mem_wr      (mem_wr),
        .reg_wr      (reg_wr),
        .IorR        (IorR),
        .PcorR       (PcorR),
        .Pc_Rst      (Pc_Rst),
        .Pc_Ld       (Pc_Ld),
        .st_reg_ld   (st_reg_ld),
        .pc_addr_sel (pc_addr_sel),
        .halted      (halted),
        .illegal     (illegal)
    );

    task automatic check_vec(input string name, input obs_t e);
        n_checks++;
        if (act === e) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, e);
    endtask

    task automatic check_int(input string name, input int got, input int want);
        n_checks++;
        if (got == want) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, got, want);
    endtask

    function automatic bit is_legal(input logic [5:0] op);
        return (op[5:4] != 2'b10 && op[5:4] != 2'b11) || op == 6'b100000 ||
               op == 6'b100001 || op == 6'b110000 || op == 6'b110001 || op == 6'b111111;
    endfunction

    // Expected per-cycle control outputs for one instruction, starting at its fetch cycle
    task automatic build_model(input logic [15:0] ins, input logic [4:0] fl, input int nhalt);
        obs_t e, a, pc;
        logic [5:0] op;
        logic [4:0] rd, rs;
        op = ins[15:10];
        rd = ins[9:5];
        rs = ins[4:0];
        exp_q.delete();
        e = '0;
        exp_q.push_back(e);
        e.illegal = !is_legal(op);
        exp_q.push_back(e);
        pc = '0;
        pc.pcorr = 1'b1;
        pc.iorr  = 1'b1;
        pc.imd   = 5'd1;
        pc.pc_ld = 1'b1;
        if (op[5] == 1'b0) begin
            a = '0;
            a.opcode = {2'b00, op[3:0]};
            a.ra1 = rd;
            a.ra2 = rs;
            a.imd = rs;
            a.iorr = op[4];
            e = a;
            e.st_ld = 1'b1;
            exp_q.push_back(e);
            e = a;
            e.reg_wr = 1'b1;
            e.din = 2'b01;
            exp_q.push_back(e);
            exp_q.push_back(pc);
        end else if (op == 6'b100000) begin
            e = '0;
            e.maddr = rs;
            e.ra1 = rd;
            exp_q.push_back(e);
            e.reg_wr = 1'b1;
            e.din = 2'b00;
            exp_q.push_back(e);
            exp_q.push_back(pc);
        end else if (op == 6'b100001) begin
            e = '0;
            e.maddr = rs;
            e.ra1 = rd;
            e.mem_wr = 1'b1;
            exp_q.push_back(e);
            exp_q.push_back(pc);
        end else if (op == 6'b110000 || (op == 6'b110001 && fl[1])) begin
            e = '0;
            e.iaddr = {6'b0, ins[9:0]};
            e.pas = 1'b1;
            e.pc_ld = 1'b1;
            exp_q.push_back(e);
        end else if (op == 6'b111111) begin
            e = '0;
            e.halted = 1'b1;
            for (int k = 0; k < nhalt; k++) exp_q.push_back(e);
        end else begin
            exp_q.push_back(pc);
        end
    endtask

    // Called one step after a rising edge with the DUT in FETCH
    task automatic run_instr(input logic [15:0] ins, input logic [4:0] fl, input int nhalt,
                             output int lat, output int nrw, output int nmw,
                             output int nill, output int njmp);
        build_model(ins, fl, nhalt);
        inst = ins;
        flags_out = fl;
        lat = 0; nrw = 0; nmw = 0; nill = 0; njmp = 0;
        for (int i = 0; i < exp_q.size(); i++) begin
            @(negedge clk);
            check_vec($sformatf("inst %h cycle %0d", ins, i), exp_q[i]);
            if (reg_wr) nrw++;
            if (mem_wr) nmw++;
            if (illegal) nill++;
            if (pc_addr_sel) njmp++;
            if (Pc_Ld && lat == 0) lat = i + 1;
            @(posedge clk);
            #1;
            // IR is loaded now; later cycles must not depend on the bus or flags
            if (i == 1) begin
                inst = 16'($urandom);
                flags_out = 5'($urandom);
                run = 1'($urandom);
            end
        end
    endtask

    task automatic do_reset_to_fetch();
        Rst = 1'b0;
        #1;
        check_vec("reset async", reset_e);
        @(negedge clk);
        check_vec("reset held", reset_e);
        @(posedge clk);
        #1;
        Rst = 1'b1;
        run = 1'b1;
        @(negedge clk);
        check_vec("reset released", reset_e);
        @(posedge clk);
        #1;
    endtask

    vec_t vecs[11];

    initial begin
        int lat, nrw, nmw, nill, njmp;
        logic [15:0] ins;
        logic [5:0]  op;

        vecs[0]  = '{16'h0022, 5'b00000, 5, 1, 0, 0, 0};
        vecs[1]  = '{16'h4443, 5'b00000, 5, 1, 0, 0, 0};
        vecs[2]  = '{16'h3C1F, 5'b11111, 5, 1, 0, 0, 0};
        vecs[3]  = '{16'h8065, 5'b00000, 5, 1, 0, 0, 0};
        vecs[4]  = '{16'h8465, 5'b00010, 4, 0, 1, 0, 0};
        vecs[5]  = '{16'hC123, 5'b00000, 3, 0, 0, 0, 1};
        vecs[6]  = '{16'hC47F, 5'b00010, 3, 0, 0, 0, 1};
        vecs[7]  = '{16'hC47F, 5'b11101, 3, 0, 0, 0, 0};
        vecs[8]  = '{16'hC47F, 5'b00001, 3, 0, 0, 0, 0};
        vecs[9]  = '{16'hB000, 5'b00000, 3, 0, 0, 1, 0};
        vecs[10] = '{16'h8865, 5'b00000, 3, 0, 0, 1, 0};

        reset_e = '0;
        reset_e.pc_rst = 1'b1;

        Rst = 1'b0;
        run = 1'b0;
        inst = 16'h0000;
        flags_out = 5'b0;
        @(negedge clk);
        check_vec("reset", reset_e);
        @(negedge clk);
        check_vec("reset", reset_e);
        @(posedge clk);
        #1;
        Rst = 1'b1;
        inst = 16'h0022;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_vec("idle run=0", reset_e);
            @(posedge clk);
            #1;
        end
        run = 1'b1;
        @(negedge clk);
        check_vec("run sampled next edge", reset_e);
        @(posedge clk);
        #1;

        for (int v = 0; v < 11; v++) begin
            run_instr(vecs[v].ins, vecs[v].fl, 0, lat, nrw, nmw, nill, njmp);
            check_int($sformatf("vec%0d latency", v), lat, vecs[v].lat);
            check_int($sformatf("vec%0d reg_wr count", v), nrw, vecs[v].nrw);
            check_int($sformatf("vec%0d mem_wr count", v), nmw, vecs[v].nmw);
            check_int($sformatf("vec%0d illegal count", v), nill, vecs[v].nill);
            check_int($sformatf("vec%0d jump count", v), njmp, vecs[v].njmp);
        end

        // HALT holds with no strobes regardless of run
        run_instr(16'hFC00, 5'b00010, 20, lat, nrw, nmw, nill, njmp);
        check_int("halt strobes", nrw + nmw + lat, 0);
        do_reset_to_fetch();

        // Reset during LOAD write-back suppresses the write at once
        run = 1'b0;
        build_model(16'h8065, 5'b0, 0);
        inst = 16'h8065;
        flags_out = 5'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_vec($sformatf("abort load cycle %0d", i), exp_q[i]);
            if (i < 3) begin
                @(posedge clk);
                #1;
            end
        end
        #1;
        Rst = 1'b0;
        #1;
        check_int("abort reg_wr", int'(reg_wr), 0);
        check_vec("abort outputs", reset_e);
        @(posedge clk);
        #1;
        do_reset_to_fetch();

        // Random program; run toggles freely and must be ignored
        for (int n = 0; n < 300; n++) begin
            case ($urandom_range(0, 6))
                0: op = {2'b00, 4'($urandom)};
                1: op = {2'b01, 4'($urandom)};
                2: op = 6'b100000;
                3: op = 6'b100001;
                4: op = 6'b110000;
                5: op = 6'b110001;
                default: begin
                    op = 6'($urandom);
                    while (is_legal(op)) op = 6'($urandom);
                end
            endcase
            ins = {op, 10'($urandom)};
            run_instr(ins, 5'($urandom), 0, lat, nrw, nmw, nill, njmp);
            check_int("random reg_wr with mem_wr", nrw * nmw, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
